// File: rtl/tdc_frame_collect.sv
// Gathers one sample per enabled TDC channel into a frame and hands it off on valid/ready.
// Writes seen while a frame waits for the consumer are counted in a saturating drop counter.
module tdc_frame_collect #(
  parameter int CH_NUM = 4,
  parameter int DATA_W = 11,
  parameter int TMO_W  = 8,
  parameter int SEQ_W  = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [CH_NUM-1:0]        ch_mask,
  input  logic [CH_NUM*DATA_W-1:0] in_data,
  input  logic [CH_NUM-1:0]        in_wr,
  input  logic [TMO_W-1:0]         tmo_limit,
  output logic [CH_NUM*DATA_W-1:0] out_data,
  output logic [CH_NUM-1:0]        out_present,
  output logic [CH_NUM-1:0]        out_dup,
  output logic [SEQ_W-1:0]         out_seq,
  output logic                     out_timeout,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [15:0]              drop_cnt
);

  localparam int PC_W = $clog2(CH_NUM + 1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_OUT     = 2'd2
  } state_t;

  function automatic logic [PC_W-1:0] popcount(input logic [CH_NUM-1:0] v);
    logic [PC_W-1:0] c;
    c = {PC_W{1'b0}};
    for (int i = 0; i < CH_NUM; i++) begin
      c = c + PC_W'(v[i]);
    end
    return c;
  endfunction

  state_t                    r_state;
  logic [CH_NUM-1:0]         r_act_mask;
  logic [CH_NUM*DATA_W-1:0]  r_slot;
  logic [CH_NUM-1:0]         r_present;
  logic [CH_NUM-1:0]         r_dup;
  logic [TMO_W-1:0]          r_tmo_cnt;
  logic [SEQ_W-1:0]          r_seq;
  logic                      r_timeout;
  logic                      r_valid;
  logic [15:0]               r_drop;

  logic                      w_fresh;
  logic [CH_NUM-1:0]         w_mask;
  logic [CH_NUM-1:0]         w_base;
  logic [CH_NUM-1:0]         w_hit;
  logic                      w_complete;
  logic                      w_tmo_hit;
  logic [CH_NUM-1:0]         w_dup_nxt;
  logic [CH_NUM*DATA_W-1:0]  w_slot_nxt;
  logic [PC_W-1:0]           w_drop_inc;
  logic [16:0]               w_drop_sum;

  // A "fresh" cycle starts a new frame against the live mask: idle, or the handshake cycle.
  always_comb begin
    w_fresh = 1'b0;
    w_mask  = r_act_mask;
    w_base  = r_present;
    case (r_state)
      ST_IDLE: begin
        w_fresh = 1'b1;
        w_mask  = ch_mask;
        w_base  = {CH_NUM{1'b0}};
      end
      ST_COLLECT: begin
        w_fresh = 1'b0;
        w_mask  = r_act_mask;
        w_base  = r_present;
      end
      ST_OUT: begin
        if (out_ready) begin
          w_fresh = 1'b1;
          w_mask  = ch_mask;
          w_base  = {CH_NUM{1'b0}};
        end else begin
          w_fresh = 1'b0;
          w_mask  = r_act_mask;
          w_base  = r_present;
        end
      end
      default: begin
        w_fresh = 1'b0;
        w_mask  = r_act_mask;
        w_base  = r_present;
      end
    endcase

    w_hit      = in_wr & w_mask;
    w_complete = ((w_base | w_hit) & w_mask) == w_mask;
    w_tmo_hit  = (tmo_limit != {TMO_W{1'b0}}) && (r_tmo_cnt == tmo_limit - TMO_W'(1));
    if (w_fresh) begin
      w_dup_nxt = {CH_NUM{1'b0}};
    end else begin
      w_dup_nxt = r_dup | (w_hit & r_present);
    end

    w_slot_nxt = r_slot;
    for (int i = 0; i < CH_NUM; i++) begin
      if (w_hit[i] && !w_base[i]) begin
        w_slot_nxt[i*DATA_W +: DATA_W] = in_data[i*DATA_W +: DATA_W];
      end else if (w_fresh) begin
        w_slot_nxt[i*DATA_W +: DATA_W] = {DATA_W{1'b0}};
      end else begin
        w_slot_nxt[i*DATA_W +: DATA_W] = r_slot[i*DATA_W +: DATA_W];
      end
    end

    if (r_state == ST_OUT && !out_ready) begin
      w_drop_inc = popcount(in_wr & r_act_mask);
    end else begin
      w_drop_inc = {PC_W{1'b0}};
    end
    w_drop_sum = {1'b0, r_drop} + 17'(w_drop_inc);
  end

  // Frame FSM; slots double as the output data registers and stay frozen in ST_OUT.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_act_mask <= {CH_NUM{1'b0}};
      r_slot     <= {(CH_NUM*DATA_W){1'b0}};
      r_present  <= {CH_NUM{1'b0}};
      r_dup      <= {CH_NUM{1'b0}};
      r_tmo_cnt  <= {TMO_W{1'b0}};
      r_seq      <= {SEQ_W{1'b0}};
      r_timeout  <= 1'b0;
      r_valid    <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_hit != {CH_NUM{1'b0}}) begin
            r_act_mask <= ch_mask;
            r_slot     <= w_slot_nxt;
            r_present  <= w_hit;
            r_dup      <= {CH_NUM{1'b0}};
            r_tmo_cnt  <= {TMO_W{1'b0}};
            r_timeout  <= 1'b0;
            r_valid    <= w_complete;
            r_state    <= w_complete ? ST_OUT : ST_COLLECT;
          end
        end
        ST_COLLECT: begin
          r_slot    <= w_slot_nxt;
          r_present <= r_present | w_hit;
          r_dup     <= w_dup_nxt;
          r_tmo_cnt <= r_tmo_cnt + TMO_W'(1);
          if (w_complete) begin
            r_state   <= ST_OUT;
            r_valid   <= 1'b1;
            r_timeout <= 1'b0;
          end else if (w_tmo_hit) begin
            r_state   <= ST_OUT;
            r_valid   <= 1'b1;
            r_timeout <= 1'b1;
          end
        end
        ST_OUT: begin
          if (out_ready) begin
            r_seq     <= r_seq + SEQ_W'(1);
            r_slot    <= w_slot_nxt;
            r_present <= w_hit;
            r_dup     <= {CH_NUM{1'b0}};
            r_tmo_cnt <= {TMO_W{1'b0}};
            r_timeout <= 1'b0;
            if (w_hit != {CH_NUM{1'b0}}) begin
              r_act_mask <= ch_mask;
              r_valid    <= w_complete;
              r_state    <= w_complete ? ST_OUT : ST_COLLECT;
            end else begin
              r_valid <= 1'b0;
              r_state <= ST_IDLE;
            end
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_valid <= 1'b0;
        end
      endcase
    end
  end

  // Saturating count of writes lost while a frame waits for the consumer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_drop <= 16'h0000;
    end else if (w_drop_sum[16]) begin
      r_drop <= 16'hFFFF;
    end else begin
      r_drop <= w_drop_sum[15:0];
    end
  end

  assign out_data    = r_slot;
  assign out_present = r_present;
  assign out_dup     = r_dup;
  assign out_seq     = r_seq;
  assign out_timeout = r_timeout;
  assign out_valid   = r_valid;
  assign drop_cnt    = r_drop;

endmodule

// File: tb/tb_tdc_frame_collect.sv
// Directed bench for tdc_frame_collect: a vector table plus hand-written corner sequences.
module tb_tdc_frame_collect;

  logic        clk;
  logic        rst;
  logic [3:0]  ch_mask;
  logic [43:0] in_data;
  logic [3:0]  in_wr;
  logic [7:0]  tmo_limit;
  logic [43:0] out_data;
  logic [3:0]  out_present;
  logic [3:0]  out_dup;
  logic [15:0] out_seq;
  logic        out_timeout;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] drop_cnt;

  int checks;
  int passed;

  tdc_frame_collect #(.CH_NUM(4), .DATA_W(11), .TMO_W(8), .SEQ_W(16)) dut (
    .clk(clk), .rst(rst), .ch_mask(ch_mask), .in_data(in_data), .in_wr(in_wr),
    .tmo_limit(tmo_limit), .out_data(out_data), .out_present(out_present),
    .out_dup(out_dup), .out_seq(out_seq), .out_timeout(out_timeout),
    .out_valid(out_valid), .out_ready(out_ready), .drop_cnt(drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  wr;
    logic [43:0] data;
    logic        ready;
    logic        exp_valid;
    logic [3:0]  exp_present;
    logic [3:0]  exp_dup;
    logic [43:0] exp_data;
    logic        exp_tmo;
    logic [15:0] exp_seq;
  } vec_t;

  vec_t vecs[14];

  function automatic logic [43:0] pk(input logic [10:0] d3, d2, d1, d0);
    return {d3, d2, d1, d0};
  endfunction

  function automatic vec_t mk(input logic [3:0] wr, input logic [43:0] data, input logic ev,
                              input logic [3:0] pres, input logic [3:0] dup,
                              input logic [43:0] ed, input logic [15:0] seq);
    vec_t v;
    v.wr = wr; v.data = data; v.ready = 1'b1; v.exp_valid = ev;
    v.exp_present = pres; v.exp_dup = dup; v.exp_data = ed; v.exp_tmo = 1'b0; v.exp_seq = seq;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) begin
      passed++;
    end else begin
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input logic [3:0] wr, input logic [43:0] data);
    in_wr   = wr;
    in_data = data;
    @(posedge clk);
    #1;
    in_wr = 4'h0;
  endtask

  initial begin
    int n;
    logic [15:0] exp_seq;
    checks = 0; passed = 0;
    rst = 1'b1; ch_mask = 4'hF; in_data = 44'h0; in_wr = 4'h0; tmo_limit = 8'd0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_valid", {63'h0, out_valid}, 64'h0);
    chk("reset_seq", {48'h0, out_seq}, 64'h0);
    chk("reset_drop", {48'h0, drop_cnt}, 64'h0);
    chk("reset_data", {20'h0, out_data}, 64'h0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    vecs[0]  = mk(4'h1, pk(11'h55, 11'h66, 11'h77, 11'd1), 1'b0, 4'h0, 4'h0, 44'h0, 16'd0);
    vecs[1]  = mk(4'h2, pk(11'h11, 11'h22, 11'd2, 11'h33), 1'b0, 4'h0, 4'h0, 44'h0, 16'd0);
    vecs[2]  = mk(4'h4, pk(11'd0, 11'd3, 11'd0, 11'd0), 1'b0, 4'h0, 4'h0, 44'h0, 16'd0);
    vecs[3]  = mk(4'h8, pk(11'd4, 11'd0, 11'd0, 11'd0), 1'b1, 4'hF, 4'h0,
                  pk(11'd4, 11'd3, 11'd2, 11'd1), 16'd0);
    vecs[4]  = mk(4'h0, 44'h0, 1'b0, 4'h0, 4'h0, 44'h0, 16'd1);
    vecs[5]  = mk(4'h2, pk(11'd0, 11'd0, 11'd5, 11'd0), 1'b0, 4'h0, 4'h0, 44'h0, 16'd1);
    vecs[6]  = mk(4'h2, pk(11'd0, 11'd0, 11'd9, 11'd0), 1'b0, 4'h0, 4'h0, 44'h0, 16'd1);
    vecs[7]  = mk(4'h1, pk(11'd0, 11'd0, 11'd0, 11'd10), 1'b0, 4'h0, 4'h0, 44'h0, 16'd1);
    vecs[8]  = mk(4'h4, pk(11'd0, 11'd11, 11'd0, 11'd0), 1'b0, 4'h0, 4'h0, 44'h0, 16'd1);
    vecs[9]  = mk(4'h8, pk(11'd12, 11'd0, 11'd0, 11'd0), 1'b1, 4'hF, 4'h2,
                  pk(11'd12, 11'd11, 11'd5, 11'd10), 16'd1);
    vecs[10] = mk(4'h0, 44'h0, 1'b0, 4'h0, 4'h0, 44'h0, 16'd2);
    vecs[11] = mk(4'hF, pk(11'd4, 11'd3, 11'd2, 11'd1), 1'b1, 4'hF, 4'h0,
                  pk(11'd4, 11'd3, 11'd2, 11'd1), 16'd2);
    vecs[12] = mk(4'hF, pk(11'd8, 11'd7, 11'd6, 11'd5), 1'b1, 4'hF, 4'h0,
                  pk(11'd8, 11'd7, 11'd6, 11'd5), 16'd3);
    vecs[13] = mk(4'h0, 44'h0, 1'b0, 4'h0, 4'h0, 44'h0, 16'd4);

    for (int i = 0; i < 14; i++) begin
      out_ready = vecs[i].ready;
      step(vecs[i].wr, vecs[i].data);
      chk($sformatf("vec%0d_valid", i), {63'h0, out_valid}, {63'h0, vecs[i].exp_valid});
      chk($sformatf("vec%0d_seq", i), {48'h0, out_seq}, {48'h0, vecs[i].exp_seq});
      if (vecs[i].exp_valid) begin
        chk($sformatf("vec%0d_data", i), {20'h0, out_data}, {20'h0, vecs[i].exp_data});
        chk($sformatf("vec%0d_present", i), {60'h0, out_present}, {60'h0, vecs[i].exp_present});
        chk($sformatf("vec%0d_dup", i), {60'h0, out_dup}, {60'h0, vecs[i].exp_dup});
        chk($sformatf("vec%0d_tmo", i), {63'h0, out_timeout}, {63'h0, vecs[i].exp_tmo});
      end
    end
    exp_seq = 16'd4;

    // Timeout: only ch0 of mask 5 writes, frame closes 10 cycles later.
    ch_mask = 4'h5; tmo_limit = 8'd10; out_ready = 1'b1;
    step(4'h1, pk(11'h0, 11'h0, 11'h0, 11'h7FF));
    n = 0;
    while (!out_valid && n < 30) begin
      step(4'h0, 44'h0);
      n++;
    end
    chk("tmo_latency", 64'(n), 64'd10);
    chk("tmo_flag", {63'h0, out_timeout}, 64'h1);
    chk("tmo_present", {60'h0, out_present}, 64'h1);
    chk("tmo_data", {20'h0, out_data}, {20'h0, pk(11'h0, 11'h0, 11'h0, 11'h7FF)});
    chk("tmo_seq", {48'h0, out_seq}, {48'h0, exp_seq});
    step(4'h0, 44'h0);
    exp_seq++;
    chk("tmo_handshake", {63'h0, out_valid}, 64'h0);

    // Back-pressure: outputs frozen and masked writes counted as drops.
    ch_mask = 4'hF; tmo_limit = 8'd0; out_ready = 1'b0;
    step(4'hF, pk(11'd1, 11'd2, 11'd3, 11'd4));
    for (int c = 0; c < 20; c++) begin
      if (c == 3) step(4'h1, pk(11'd9, 11'd9, 11'd9, 11'd9));
      else if (c == 10) step(4'h6, pk(11'd9, 11'd9, 11'd9, 11'd9));
      else step(4'h0, 44'h0);
      chk($sformatf("hold%0d_data", c), {20'h0, out_data}, {20'h0, pk(11'd1, 11'd2, 11'd3, 11'd4)});
      chk($sformatf("hold%0d_valid", c), {63'h0, out_valid}, 64'h1);
    end
    chk("drop_cnt", {48'h0, drop_cnt}, 64'd3);
    chk("hold_seq", {48'h0, out_seq}, {48'h0, exp_seq});
    out_ready = 1'b1;
    step(4'h0, 44'h0);
    exp_seq++;
    chk("hold_release_valid", {63'h0, out_valid}, 64'h0);
    chk("hold_release_seq", {48'h0, out_seq}, {48'h0, exp_seq});

    // Asynchronous reset in the middle of a partial frame.
    step(4'h3, pk(11'h0, 11'h0, 11'h0AA, 11'h0BB));
    chk("pre_rst_valid", {63'h0, out_valid}, 64'h0);
    rst = 1'b1;
    #2;
    chk("rst_valid", {63'h0, out_valid}, 64'h0);
    chk("rst_drop", {48'h0, drop_cnt}, 64'h0);
    chk("rst_seq", {48'h0, out_seq}, 64'h0);
    chk("rst_present", {60'h0, out_present}, 64'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_seq = 16'd0;
    step(4'hC, pk(11'h0DD, 11'h0CC, 11'h111, 11'h111));
    chk("post_rst_partial", {63'h0, out_valid}, 64'h0);
    step(4'h3, pk(11'h0, 11'h0, 11'h0EE, 11'h0FF));
    chk("post_rst_valid", {63'h0, out_valid}, 64'h1);
    chk("post_rst_data", {20'h0, out_data}, {20'h0, pk(11'h0DD, 11'h0CC, 11'h0EE, 11'h0FF)});
    chk("post_rst_dup", {60'h0, out_dup}, 64'h0);
    chk("post_rst_seq", {48'h0, out_seq}, 64'h0);
    step(4'h0, 44'h0);
    exp_seq++;

    // Empty mask: nothing accepted, nothing counted.
    ch_mask = 4'h0;
    for (int c = 0; c < 5; c++) begin
      step(4'hF, pk(11'd1, 11'd1, 11'd1, 11'd1));
      chk($sformatf("mask0_%0d_valid", c), {63'h0, out_valid}, 64'h0);
    end
    chk("mask0_drop", {48'h0, drop_cnt}, 64'h0);

    // Mask change mid-frame only applies to the next frame.
    ch_mask = 4'h3;
    step(4'h1, pk(11'h0, 11'h0, 11'h0, 11'h021));
    ch_mask = 4'hF;
    step(4'h6, pk(11'h0, 11'h033, 11'h022, 11'h0));
    chk("mchg_valid", {63'h0, out_valid}, 64'h1);
    chk("mchg_present", {60'h0, out_present}, 64'h3);
    chk("mchg_data", {20'h0, out_data}, {20'h0, pk(11'h0, 11'h0, 11'h022, 11'h021)});
    chk("mchg_seq", {48'h0, out_seq}, {48'h0, exp_seq});
    step(4'h0, 44'h0);
    exp_seq++;

    // tmo_limit = 0 never times out, even past a counter wrap.
    ch_mask = 4'h3; tmo_limit = 8'd0;
    step(4'h1, pk(11'h0, 11'h0, 11'h0, 11'h005));
    n = 0;
    for (int c = 0; c < 300; c++) begin
      step(4'h0, 44'h0);
      if (out_valid) n++;
    end
    chk("notmo_no_valid", 64'(n), 64'd0);
    step(4'h2, pk(11'h0, 11'h0, 11'h006, 11'h0));
    chk("notmo_valid", {63'h0, out_valid}, 64'h1);
    chk("notmo_flag", {63'h0, out_timeout}, 64'h0);
    chk("notmo_data", {20'h0, out_data}, {20'h0, pk(11'h0, 11'h0, 11'h006, 11'h005)});
    step(4'h0, 44'h0);
    exp_seq++;
    chk("notmo_seq", {48'h0, out_seq}, {48'h0, exp_seq});

    // Drop counter saturation.
    ch_mask = 4'hF; out_ready = 1'b0;
    step(4'hF, pk(11'd1, 11'd1, 11'd1, 11'd1));
    for (int c = 0; c < 16400; c++) begin
      step(4'hF, pk(11'd2, 11'd2, 11'd2, 11'd2));
    end
    chk("drop_sat", {48'h0, drop_cnt}, 64'hFFFF);
    chk("drop_sat_data", {20'h0, out_data}, {20'h0, pk(11'd1, 11'd1, 11'd1, 11'd1)});
    out_ready = 1'b1;
    step(4'h0, 44'h0);
    exp_seq++;
    chk("final_seq", {48'h0, out_seq}, {48'h0, exp_seq});
    chk("final_valid", {63'h0, out_valid}, 64'h0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
